// File: rtl/m_stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, saturation value,
// and the next-state rule used by the sequencing FSM.
// Pure definitions, no logic of its own.
package m_stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_LAP  = 3'd2,
    ST_STOP = 3'd3,
    ST_OVER = 3'd4
  } sw_state_t;

  // BCD value at which the counter chain stops advancing
  localparam logic [15:0] SW_MAXVAL = 16'h9999;

  // Next state from the current state and this cycle's events.
  // sat (tick due while chain already at max) outranks the buttons: the count
  // cannot go further, so the run ends regardless of what the user pressed.
  function automatic sw_state_t sw_next(input sw_state_t cur, input logic ss,
                                        input logic lap, input logic sat);
    sw_state_t nxt;
    nxt = cur;
    case (cur)
      ST_IDLE: if (ss) nxt = ST_RUN;
      ST_RUN: begin
        if (sat)      nxt = ST_OVER;
        else if (ss)  nxt = ST_STOP;
        else if (lap) nxt = ST_LAP;
      end
      ST_LAP: begin
        if (sat)      nxt = ST_OVER;
        else if (ss)  nxt = ST_STOP;
        else if (lap) nxt = ST_RUN;
      end
      ST_STOP: begin
        if (ss)       nxt = ST_RUN;
        else if (lap) nxt = ST_IDLE;
      end
      ST_OVER: if (lap) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/m_stopwatch_ctrl_tick_gen.sv
// Prescaler producing the base count tick every TICK_DIV enabled cycles.
// tick is combinational from the count register and en (same cycle).
// en=0 holds the fraction, clr forces the count back to zero.
module m_tick_gen #(
  parameter int TICK_DIV = 500000
) (
  input  logic clk,
  input  logic n_reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] count;

  // Count 0..TICK_DIV-1 while enabled, clear has priority
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  // Tick is due on the last cycle of each prescaler period
  always_comb begin
    tick = en & (count == LAST);
  end

endmodule

// File: rtl/m_stopwatch_ctrl.sv
// Start/stop/lap sequencer for the 4-digit BCD stopwatch chain; drives tick, clear and display.
// cnt_en/disp_q are combinational from registers and cnt_q; state outputs update one cycle after a press.
// No backpressure: button edges act immediately, ss wins over lap in the same cycle.
module m_stopwatch_ctrl
  import m_stopwatch_ctrl_pkg::*;
#(
  parameter int          TICK_DIV = 500000,
  parameter logic [15:0] MAXVAL   = SW_MAXVAL
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        btn_ss,
  input  logic        btn_lap,
  input  logic [15:0] cnt_q,
  output logic        cnt_en,
  output logic        cnt_clr_n,
  output logic [15:0] disp_q,
  output logic        running,
  output logic        lap_hold,
  output logic        over
);

  sw_state_t   state;
  sw_state_t   nxt;
  logic        prev_ss;
  logic        prev_lap;
  logic        ss_rise;
  logic        lap_rise;
  logic        tick_due;
  logic        at_max;
  logic        sat;
  logic        presc_clr;
  logic [15:0] lap_latch;

  // Prescaler runs in RUN/LAP, holds in STOP, is zeroed in IDLE/OVER
  always_comb begin
    presc_clr = (state == ST_IDLE) | (state == ST_OVER);
  end

  m_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk     (clk),
    .n_reset (n_reset),
    .en      (running),
    .clr     (presc_clr),
    .tick    (tick_due)
  );

  // Edge detect, tick qualification and display mux
  always_comb begin
    ss_rise  = btn_ss & ~prev_ss;
    lap_rise = btn_lap & ~prev_lap & ~ss_rise;
    at_max   = (cnt_q == MAXVAL);
    cnt_en   = tick_due & ~at_max;
    sat      = tick_due & at_max;
    nxt      = sw_next(state, ss_rise, lap_rise, sat);
    disp_q   = lap_hold ? lap_latch : cnt_q;
  end

  // Previous button levels; reset to 1 so a button held through reset is not an edge
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      prev_ss  <= 1'b1;
      prev_lap <= 1'b1;
    end else begin
      prev_ss  <= btn_ss;
      prev_lap <= btn_lap;
    end
  end

  // FSM with registered state decodes, clear pulse and lap capture
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= ST_IDLE;
      running   <= 1'b0;
      lap_hold  <= 1'b0;
      over      <= 1'b0;
      cnt_clr_n <= 1'b1;
      lap_latch <= '0;
    end else begin
      state     <= nxt;
      running   <= (nxt == ST_RUN) | (nxt == ST_LAP);
      lap_hold  <= (nxt == ST_LAP);
      over      <= (nxt == ST_OVER);
      // Clear the chain for exactly the cycle in which IDLE is entered from STOP/OVER
      cnt_clr_n <= ~(((state == ST_STOP) | (state == ST_OVER)) & (nxt == ST_IDLE));
      // Capture the pre-increment value seen in the lap press cycle
      if ((state == ST_RUN) && (nxt == ST_LAP)) lap_latch <= cnt_q;
    end
  end

endmodule

// File: tb/tb_m_stopwatch_ctrl.sv
// Bench for m_stopwatch_ctrl with TICK_DIV=4 and a modelled BCD counter chain.
module tb_m_stopwatch_ctrl;

  localparam int TD = 4;

  logic        clk;
  logic        n_reset;
  logic        btn_ss;
  logic        btn_lap;
  logic [15:0] cnt_q;
  logic        cnt_en;
  logic        cnt_clr_n;
  logic [15:0] disp_q;
  logic        running;
  logic        lap_hold;
  logic        over;

  int errors = 0;
  int checks = 0;

  // chain preload request (environment side)
  logic        pre_req;
  logic [15:0] pre_val;

  // behavioural model state
  bit          m_on;      // counting (RUN or LAP)
  bit          m_frz;     // display frozen
  bit          m_ovr;     // saturated
  bit          m_pause;   // stopped with count kept
  int          m_ph;      // cycles into current tick period
  logic [15:0] m_latch;
  bit          m_clrn;
  bit          m_pss;
  bit          m_plap;

  m_stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .btn_ss    (btn_ss),
    .btn_lap   (btn_lap),
    .cnt_q     (cnt_q),
    .cnt_en    (cnt_en),
    .cnt_clr_n (cnt_clr_n),
    .disp_q    (disp_q),
    .running   (running),
    .lap_hold  (lap_hold),
    .over      (over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    bit c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[i*4 +: 4] == 4'd9) r[i*4 +: 4] = 4'd0;
        else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Counter chain: async clear, +1 BCD per cnt_en
  always @(posedge clk or negedge cnt_clr_n or negedge n_reset) begin
    if (!n_reset || !cnt_clr_n) cnt_q <= 16'h0000;
    else if (pre_req)           cnt_q <= pre_val;
    else if (cnt_en)            cnt_q <= bcd_inc(cnt_q);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called 1 time unit after a rising edge: apply inputs, settle to just before next edge
  task automatic drive(input logic s, input logic l);
    btn_ss  = s;
    btn_lap = l;
    #7;
  endtask

  // Compare every output to the model, advance the model, move to after the next edge
  task automatic fin();
    bit due, ss, lap, sat, e_en;
    logic [15:0] e_disp;
    if (!n_reset) begin
      m_on = 0; m_frz = 0; m_ovr = 0; m_pause = 0; m_ph = 0;
      m_latch = 16'h0; m_clrn = 1; m_pss = 1; m_plap = 1;
    end
    due    = m_on && (m_ph == TD - 1);
    e_en   = due && (cnt_q != 16'h9999);
    e_disp = m_frz ? m_latch : cnt_q;
    chk("model running", running, m_on);
    chk("model lap_hold", lap_hold, m_frz);
    chk("model over", over, m_ovr);
    chk("model cnt_clr_n", cnt_clr_n, m_clrn);
    chk("model cnt_en", cnt_en, e_en);
    chk("model disp_q", disp_q, e_disp);
    if (n_reset) begin
      ss  = btn_ss && !m_pss;
      lap = btn_lap && !m_plap && !ss;
      sat = due && (cnt_q == 16'h9999);
      if (m_on) m_ph = (m_ph + 1) % TD;
      else if (!m_pause) m_ph = 0;
      m_clrn = 1;
      if (m_on) begin
        if (sat) begin
          m_on = 0; m_frz = 0; m_ovr = 1;
        end else if (ss) begin
          m_on = 0; m_frz = 0; m_pause = 1;
        end else if (lap) begin
          if (m_frz) m_frz = 0;
          else begin
            m_frz = 1;
            m_latch = cnt_q;
          end
        end
      end else if (m_ovr) begin
        if (lap) begin
          m_ovr = 0; m_clrn = 0;
        end
      end else if (m_pause) begin
        if (ss) begin
          m_pause = 0; m_on = 1;
        end else if (lap) begin
          m_pause = 0; m_clrn = 0;
        end
      end else if (ss) begin
        m_on = 1;
      end
      m_pss  = btn_ss;
      m_plap = btn_lap;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic s, input logic l);
    drive(s, l);
    fin();
  endtask

  initial begin
    int n;
    int ticks;
    bit seen;
    logic [15:0] v;
    n_reset = 1'b0;
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    pre_req = 1'b0;
    pre_val = 16'h0;
    @(posedge clk);
    #1;

    // reset state
    drive(0, 0);
    chk("reset running", running, 1'b0);
    chk("reset cnt_clr_n", cnt_clr_n, 1'b1);
    chk("reset disp_q", disp_q, 16'h0000);
    fin();
    cyc(0, 0);
    n_reset = 1'b1;
    cyc(0, 0);

    // start: first tick on the 4th RUN cycle
    drive(1, 0);
    chk("t1 idle before", running, 1'b0);
    fin();
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0);
      chk("t1 running", running, 1'b1);
      chk("t1 cnt_en", cnt_en, (k == 4));
      fin();
    end
    drive(0, 0);
    chk("t1 cnt_q", cnt_q, 16'h0001);
    fin();

    // lap freeze at 0012
    n = 0;
    while (cnt_q != 16'h0012 && n < 200) begin
      cyc(0, 0);
      n++;
    end
    chk("t2 reach 0012", cnt_q, 16'h0012);
    cyc(0, 1);
    for (int k = 0; k < 10; k++) cyc(0, 0);
    drive(0, 0);
    chk("t2 frozen disp", disp_q, 16'h0012);
    chk("t2 live cnt", cnt_q, 16'h0014);
    chk("t2 lap_hold", lap_hold, 1'b1);
    fin();
    cyc(0, 1);
    drive(0, 0);
    chk("t2 released", lap_hold, 1'b0);
    chk("t2 disp live", disp_q, cnt_q);
    fin();

    // stop at prescaler=2, resume keeps fraction
    seen = 0;
    n = 0;
    while (!seen && n < 20) begin
      drive(0, 0);
      seen = cnt_en;
      fin();
      n++;
    end
    chk("t3 tick seen", seen, 1'b1);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 0);
    for (int k = 0; k < 20; k++) begin
      drive(0, 0);
      chk("t3 stop no tick", cnt_en, 1'b0);
      fin();
    end
    v = cnt_q;
    drive(1, 0);
    chk("t3 press cycle", cnt_en, 1'b0);
    fin();
    drive(0, 0);
    chk("t3 tick after resume", cnt_en, 1'b1);
    fin();
    chk("t3 cnt advanced", cnt_q, bcd_inc(v));

    // stop then lap: clear pulse, back to idle
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 1);
    drive(0, 0);
    chk("t4 clr pulse", cnt_clr_n, 1'b0);
    chk("t4 idle", running, 1'b0);
    chk("t4 cnt_q", cnt_q, 16'h0000);
    chk("t4 disp_q", disp_q, 16'h0000);
    fin();
    drive(0, 0);
    chk("t4 clr one cycle", cnt_clr_n, 1'b1);
    fin();

    // saturation at 9999
    cyc(1, 0);
    pre_val = 16'h9998;
    pre_req = 1'b1;
    cyc(0, 0);
    pre_req = 1'b0;
    ticks = 0;
    n = 0;
    while (!over && n < 40) begin
      drive(0, 0);
      if (cnt_en) ticks++;
      fin();
      n++;
    end
    chk("t5 one tick", 16'(ticks), 16'd1);
    chk("t5 cnt_q max", cnt_q, 16'h9999);
    chk("t5 over", over, 1'b1);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0);
      drive(0, 0);
      chk("t5 ss ignored", over, 1'b1);
      chk("t5 no tick", cnt_en, 1'b0);
      fin();
    end
    cyc(0, 1);
    drive(0, 0);
    chk("t5 clr", cnt_clr_n, 1'b0);
    chk("t5 over cleared", over, 1'b0);
    chk("t5 cnt_q cleared", cnt_q, 16'h0000);
    fin();

    // simultaneous rises, held button through reset, reset mid-run
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    cyc(1, 1);
    drive(0, 0);
    chk("t6 both stop", running, 1'b0);
    chk("t6 both lap_hold", lap_hold, 1'b0);
    chk("t6 both no clr", cnt_clr_n, 1'b1);
    fin();
    n_reset = 1'b0;
    cyc(1, 0);
    cyc(1, 0);
    n_reset = 1'b1;
    cyc(1, 0);
    drive(1, 0);
    chk("t6 held ss", running, 1'b0);
    fin();
    cyc(0, 0);
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 1);
    drive(0, 0);
    chk("t6 in lap", lap_hold, 1'b1);
    fin();
    n_reset = 1'b0;
    drive(0, 0);
    chk("t6 rst running", running, 1'b0);
    chk("t6 rst lap_hold", lap_hold, 1'b0);
    chk("t6 rst cnt_en", cnt_en, 1'b0);
    chk("t6 rst cnt_clr_n", cnt_clr_n, 1'b1);
    chk("t6 rst disp_q", disp_q, 16'h0000);
    fin();
    n_reset = 1'b1;
    cyc(0, 0);

    // randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      n_reset = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 199) == 0) begin
        pre_req = 1'b1;
        if ($urandom_range(0, 1) == 1)
          pre_val = 16'h9990 + 16'($urandom_range(0, 9));
        else
          pre_val = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      end else begin
        pre_req = 1'b0;
      end
      cyc(($urandom_range(0, 24) == 0), ($urandom_range(0, 14) == 0));
    end
    pre_req = 1'b0;
    n_reset = 1'b1;
    cyc(0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
